// File: rtl/mru_hist_arbiter.sv
// mru_hist_arbiter
//   Round-robin arbiter in front of a shared most-recently-used history of
//   distinct sample values. Each granted sample is looked up (hit/miss plus
//   position) and the history is then reordered move-to-front, newest entry
//   at index 0.
//
//   Optional feature macro: MRU_HIST_STATS_EN builds saturating hit/miss
//   counters. When it is undefined, hit_cnt_out and miss_cnt_out read 0.
//
// Ports
//   clk_in          rising-edge clock
//   reset_n_in      asynchronous active-low reset
//   req_valid_in    per-requester sample valid
//   req_data_in     per-requester sample, requester i at [i*DATA_W +: DATA_W]
//   req_ready_out   one-hot grant, combinational, only in the idle state
//   clear_in        empty the history (held pending if not idle)
//   rsp_valid_out   one-cycle response pulse
//   rsp_id_out      requester being answered
//   rsp_hit_out     sample was already present
//   rsp_pos_out     hit position (0 = newest), 0 on miss
//   hist_data_out   history entries, entry 0 = newest
//   hist_valid_out  entry-valid bits, contiguous from bit 0
//   hit_cnt_out     response hit counter
//   miss_cnt_out    response miss counter
module mru_hist_arbiter #(
  parameter int DATA_W     = 8,
  parameter int NUM_REQ    = 4,
  parameter int HIST_DEPTH = 4
) (
  input  logic                           clk_in,
  input  logic                           reset_n_in,
  input  logic [NUM_REQ-1:0]             req_valid_in,
  input  logic [NUM_REQ*DATA_W-1:0]      req_data_in,
  output logic [NUM_REQ-1:0]             req_ready_out,
  input  logic                           clear_in,
  output logic                           rsp_valid_out,
  output logic [$clog2(NUM_REQ)-1:0]     rsp_id_out,
  output logic                           rsp_hit_out,
  output logic [$clog2(HIST_DEPTH)-1:0]  rsp_pos_out,
  output logic [HIST_DEPTH*DATA_W-1:0]   hist_data_out,
  output logic [HIST_DEPTH-1:0]          hist_valid_out,
  output logic [15:0]                    hit_cnt_out,
  output logic [15:0]                    miss_cnt_out
);

  localparam int IDW  = $clog2(NUM_REQ);
  localparam int POSW = $clog2(HIST_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_UPDATE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [IDW-1:0]    ptr;
  logic              clear_pend;
  logic [DATA_W-1:0] hist_q   [HIST_DEPTH];
  logic [DATA_W-1:0] hist_upd [HIST_DEPTH];
  logic [HIST_DEPTH-1:0] hist_vld;
  logic [HIST_DEPTH-1:0] vld_upd;

  logic              found;
  logic [IDW-1:0]    win;
  logic [IDW-1:0]    ptr_nxt;
  logic              clear_now;
  logic              grant;

  logic [DATA_W-1:0] samp_p0;
  logic [IDW-1:0]    id_p0;
  logic              lk_hit;
  logic [POSW-1:0]   lk_pos;
  logic              hit_p1;
  logic [POSW-1:0]   pos_p1;

  // A pending clear always beats a request in the idle state.
  assign clear_now = (state == ST_IDLE) && (clear_in || clear_pend);
  assign grant     = (state == ST_IDLE) && !clear_now && found;

  // Round-robin search upward from ptr, wrapping modulo NUM_REQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req_valid_in[(int'(ptr) + k) % NUM_REQ]) begin
        found = 1'b1;
        win   = IDW'((int'(ptr) + k) % NUM_REQ);
      end
    end
  end

  assign ptr_nxt = (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;

  // State register
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) state <= ST_IDLE;
    else             state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (grant) state_nxt = ST_LOOKUP;
      ST_LOOKUP: state_nxt = ST_UPDATE;
      ST_UPDATE: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Output logic; the grant is masked while reset is held.
  always_comb begin
    req_ready_out = '0;
    if (grant && reset_n_in) req_ready_out[win] = 1'b1;
    rsp_valid_out = (state == ST_UPDATE);
    rsp_id_out    = (state == ST_UPDATE) ? id_p0  : '0;
    rsp_hit_out   = (state == ST_UPDATE) ? hit_p1 : 1'b0;
    rsp_pos_out   = (state == ST_UPDATE) ? pos_p1 : '0;
  end

  // Lookup against valid entries; the downward scan leaves the lowest index.
  always_comb begin
    lk_hit = 1'b0;
    lk_pos = '0;
    for (int i = HIST_DEPTH - 1; i >= 0; i--) begin
      if (hist_vld[i] && (hist_q[i] == samp_p0)) begin
        lk_hit = 1'b1;
        lk_pos = POSW'(i);
      end
    end
  end

  // Move-to-front. Invalid entries hold 0, so a miss can shift the whole
  // array and still leave zeros beyond the new valid boundary.
  always_comb begin
    hist_upd    = hist_q;
    hist_upd[0] = samp_p0;
    for (int i = 1; i < HIST_DEPTH; i++) begin
      if (!hit_p1 || (i <= int'(pos_p1))) hist_upd[i] = hist_q[i-1];
    end
    vld_upd = hit_p1 ? hist_vld : {hist_vld[HIST_DEPTH-2:0], 1'b1};
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      ptr        <= '0;
      clear_pend <= 1'b0;
      samp_p0    <= '0;
      id_p0      <= '0;
      hit_p1     <= 1'b0;
      pos_p1     <= '0;
      hist_vld   <= '0;
      for (int i = 0; i < HIST_DEPTH; i++) hist_q[i] <= '0;
    end else begin
      // p0: capture the granted sample
      if (grant) begin
        samp_p0 <= req_data_in[int'(win)*DATA_W +: DATA_W];
        id_p0   <= win;
        ptr     <= ptr_nxt;
      end
      // p1: register the lookup result
      if (state == ST_LOOKUP) begin
        hit_p1 <= lk_hit;
        pos_p1 <= lk_pos;
      end
      if (clear_in && (state != ST_IDLE)) clear_pend <= 1'b1;
      else if (clear_now)                 clear_pend <= 1'b0;
      if (clear_now) begin
        hist_vld <= '0;
        for (int i = 0; i < HIST_DEPTH; i++) hist_q[i] <= '0;
      end else if (state == ST_UPDATE) begin
        hist_vld <= vld_upd;
        hist_q   <= hist_upd;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < HIST_DEPTH; i++) hist_data_out[i*DATA_W +: DATA_W] = hist_q[i];
  end
  assign hist_valid_out = hist_vld;

`ifdef MRU_HIST_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (clear_now) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (state == ST_UPDATE) begin
      if (hit_p1) hit_cnt  <= sat_inc(hit_cnt);
      else        miss_cnt <= sat_inc(miss_cnt);
    end
  end

  assign hit_cnt_out  = hit_cnt;
  assign miss_cnt_out = miss_cnt;
`else
  assign hit_cnt_out  = 16'd0;
  assign miss_cnt_out = 16'd0;
`endif

endmodule
